// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: D-stage stall/bubble control and mult/div busy sequencing
module pipe_hazard_ctrl #(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  rs_tuse_D,
    input  logic [1:0]  rt_tuse_D,
    input  logic [4:0]  wa_E,
    input  logic [1:0]  tnew_E,
    input  logic [4:0]  wa_M,
    input  logic [1:0]  tnew_M,
    input  logic        md_start_D,
    input  logic        md_div_D,
    input  logic        md_use_D,
    output logic        en_PC,
    output logic        en_IFID,
    output logic        flush_IDEX,
    output logic        md_start_E,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    localparam logic [3:0] L_MUL = MUL_CYC[3:0];
    localparam logic [3:0] L_DIV = DIV_CYC[3:0];
    state_t      r_state;
    logic [3:0]  r_md_cnt;
    logic        r_md_busy;
    logic        r_md_start_E;
    logic [31:0] r_stall_cnt;
    logic        w_hz_rs_E, w_hz_rs_M, w_hz_rt_E, w_hz_rt_M;
    logic        w_stall, w_issue;
    // a writer stalls D only if its result is not yet forwardable when D's consumer needs it
    always_comb begin
        w_hz_rs_E = (rs_tuse_D != 2'd3) && (wa_E != 5'd0) && (wa_E == rs_D) && (tnew_E > rs_tuse_D);
        w_hz_rs_M = (rs_tuse_D != 2'd3) && (wa_M != 5'd0) && (wa_M == rs_D) && (tnew_M > rs_tuse_D);
        w_hz_rt_E = (rt_tuse_D != 2'd3) && (wa_E != 5'd0) && (wa_E == rt_D) && (tnew_E > rt_tuse_D);
        w_hz_rt_M = (rt_tuse_D != 2'd3) && (wa_M != 5'd0) && (wa_M == rt_D) && (tnew_M > rt_tuse_D);
        w_stall   = w_hz_rs_E || w_hz_rs_M || w_hz_rt_E || w_hz_rt_M
                    || ((md_use_D || md_start_D) && r_md_busy);
        w_issue   = md_start_D && !w_stall;
    end
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_md_cnt     <= 4'd0;
            r_md_busy    <= 1'b0;
            r_md_start_E <= 1'b0;
            r_stall_cnt  <= 32'd0;
        end else begin
            r_md_start_E <= w_issue;
            if (w_stall && r_stall_cnt != 32'hFFFF_FFFF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (r_state == IDLE) begin
                if (w_issue) begin
                    r_state   <= md_div_D ? DIV : MUL;
                    r_md_cnt  <= md_div_D ? L_DIV : L_MUL;
                    r_md_busy <= 1'b1;
                end
            end else if (r_md_cnt == 4'd1) begin
                r_state   <= IDLE;
                r_md_cnt  <= 4'd0;
                r_md_busy <= 1'b0;
            end else begin
                r_md_cnt <= r_md_cnt - 4'd1;
            end
        end
    end
    assign en_PC      = !w_stall;
    assign en_IFID    = !w_stall;
    assign flush_IDEX = w_stall;
    assign md_start_E = r_md_start_E;
    assign md_busy    = r_md_busy;
    assign stall_cnt  = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenario tests for pipe_hazard_ctrl (MUL_CYC=5, DIV_CYC=10)
module tb_pipe_hazard_ctrl;
    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  rs_D, rt_D, wa_E, wa_M;
    logic [1:0]  rs_tuse_D, rt_tuse_D, tnew_E, tnew_M;
    logic        md_start_D, md_div_D, md_use_D;
    logic        en_PC, en_IFID, flush_IDEX, md_start_E, md_busy;
    logic [31:0] stall_cnt;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] exp_cnt = 32'd0;

    pipe_hazard_ctrl #(.MUL_CYC(5), .DIV_CYC(10)) dut (
        .CLK(CLK), .reset(reset), .rs_D(rs_D), .rt_D(rt_D),
        .rs_tuse_D(rs_tuse_D), .rt_tuse_D(rt_tuse_D),
        .wa_E(wa_E), .tnew_E(tnew_E), .wa_M(wa_M), .tnew_M(tnew_M),
        .md_start_D(md_start_D), .md_div_D(md_div_D), .md_use_D(md_use_D),
        .en_PC(en_PC), .en_IFID(en_IFID), .flush_IDEX(flush_IDEX),
        .md_start_E(md_start_E), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        rs_D = 5'd0; rt_D = 5'd0; rs_tuse_D = 2'd3; rt_tuse_D = 2'd3;
        wa_E = 5'd0; tnew_E = 2'd0; wa_M = 5'd0; tnew_M = 2'd0;
        md_start_D = 1'b0; md_div_D = 1'b0; md_use_D = 1'b0;
    endtask

    // inputs change 1 time unit after the rising edge; outputs are sampled 1 unit after that
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1;
        n_chk++; if (md_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", md_busy); else n_pass++;
        n_chk++; if (md_start_E !== 1'b0) $display("FAIL reset_start_e: got %b want 0", md_start_E); else n_pass++;
        n_chk++; if (stall_cnt !== 32'd0) $display("FAIL reset_cnt: got %h want 0", stall_cnt); else n_pass++;
        n_chk++; if ({en_PC, en_IFID, flush_IDEX} !== 3'b110) $display("FAIL reset_ctrl: got %b want 110", {en_PC, en_IFID, flush_IDEX}); else n_pass++;
        @(negedge CLK);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        idle_inputs();
        rs_D = 5'd5; rs_tuse_D = 2'd1; wa_E = 5'd5; tnew_E = 2'd2;
        #1;
        n_chk++; if ({en_PC, en_IFID, flush_IDEX} !== 3'b001) $display("FAIL load_use_stall: got %b want 001", {en_PC, en_IFID, flush_IDEX}); else n_pass++;
        tick();
        exp_cnt = exp_cnt + 1;
        n_chk++; if (stall_cnt !== exp_cnt) $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, exp_cnt); else n_pass++;
        wa_E = 5'd0; wa_M = 5'd5; tnew_M = 2'd1;
        #1;
        n_chk++; if ({en_PC, en_IFID, flush_IDEX} !== 3'b110) $display("FAIL load_use_release: got %b want 110", {en_PC, en_IFID, flush_IDEX}); else n_pass++;
        tnew_M = 2'd2;
        #1;
        n_chk++; if (flush_IDEX !== 1'b1) $display("FAIL rs_m_hazard: got %b want 1", flush_IDEX); else n_pass++;
        idle_inputs();
        rt_D = 5'd9; rt_tuse_D = 2'd1; wa_M = 5'd9; tnew_M = 2'd2;
        #1;
        n_chk++; if (flush_IDEX !== 1'b1) $display("FAIL rt_m_hazard: got %b want 1", flush_IDEX); else n_pass++;
        tick();
        exp_cnt = exp_cnt + 1;
        idle_inputs();
        #1;
        n_chk++; if (stall_cnt !== exp_cnt) $display("FAIL m_hazard_cnt: got %0d want %0d", stall_cnt, exp_cnt); else n_pass++;
    endtask

    task automatic test_branch();
        idle_inputs();
        rt_D = 5'd8; rt_tuse_D = 2'd0; wa_E = 5'd8; tnew_E = 2'd1;
        #1;
        n_chk++; if ({en_PC, flush_IDEX} !== 2'b01) $display("FAIL branch_stall: got %b want 01", {en_PC, flush_IDEX}); else n_pass++;
        wa_E = 5'd0; rt_D = 5'd0;
        #1;
        n_chk++; if ({en_PC, flush_IDEX} !== 2'b10) $display("FAIL branch_zero_reg: got %b want 10", {en_PC, flush_IDEX}); else n_pass++;
        rs_D = 5'd0; rs_tuse_D = 2'd0; tnew_E = 2'd3;
        #1;
        n_chk++; if (flush_IDEX !== 1'b0) $display("FAIL r0_no_stall: got %b want 0", flush_IDEX); else n_pass++;
        idle_inputs();
        rt_D = 5'd8; wa_E = 5'd8; tnew_E = 2'd2;
        #1;
        n_chk++; if (flush_IDEX !== 1'b0) $display("FAIL tuse3_no_stall: got %b want 0", flush_IDEX); else n_pass++;
        rt_tuse_D = 2'd2;
        #1;
        n_chk++; if (flush_IDEX !== 1'b0) $display("FAIL tnew_eq_tuse: got %b want 0", flush_IDEX); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_mult_mflo();
        int b;
        idle_inputs();
        md_start_D = 1'b1;
        #1;
        n_chk++; if (flush_IDEX !== 1'b0) $display("FAIL mult_issue_stall: got %b want 0", flush_IDEX); else n_pass++;
        tick();
        md_start_D = 1'b0; md_use_D = 1'b1;
        // first busy cycle also carries a data hazard: still a single stall
        rs_D = 5'd3; rs_tuse_D = 2'd1; wa_E = 5'd3; tnew_E = 2'd2;
        #1;
        n_chk++; if ({md_start_E, md_busy} !== 2'b11) $display("FAIL mult_start: got %b want 11", {md_start_E, md_busy}); else n_pass++;
        b = 0;
        for (int i = 0; i < 5; i++) begin
            if (md_busy === 1'b1 && flush_IDEX === 1'b1) b++;
            tick();
            rs_D = 5'd0; rs_tuse_D = 2'd3; wa_E = 5'd0; tnew_E = 2'd0;
            if (i == 0) begin
                n_chk++; if (md_start_E !== 1'b0) $display("FAIL mult_pulse_width: got %b want 0", md_start_E); else n_pass++;
            end
        end
        exp_cnt = exp_cnt + 5;
        #1;
        n_chk++; if (b != 5) $display("FAIL mult_busy_cycles: got %0d want 5", b); else n_pass++;
        n_chk++; if ({md_busy, flush_IDEX} !== 2'b00) $display("FAIL mflo_release: got %b want 00", {md_busy, flush_IDEX}); else n_pass++;
        n_chk++; if (stall_cnt !== exp_cnt) $display("FAIL mult_cnt: got %0d want %0d", stall_cnt, exp_cnt); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int stalls = 0;
        idle_inputs();
        md_start_D = 1'b1; md_div_D = 1'b1;
        tick();
        if (md_start_E === 1'b1) pulses++;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (flush_IDEX === 1'b1) stalls++;
            tick();
            if (md_start_E === 1'b1) pulses++;
        end
        exp_cnt = exp_cnt + 10;
        n_chk++; if (stalls != 10) $display("FAIL div_div_stalls: got %0d want 10", stalls); else n_pass++;
        n_chk++; if ({md_busy, flush_IDEX} !== 2'b00) $display("FAIL div_div_issue: got %b want 00", {md_busy, flush_IDEX}); else n_pass++;
        tick();
        if (md_start_E === 1'b1) pulses++;
        md_start_D = 1'b0; md_div_D = 1'b0;
        n_chk++; if (md_busy !== 1'b1) $display("FAIL div2_busy: got %b want 1", md_busy); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (md_start_E === 1'b1) pulses++;
        end
        n_chk++; if (pulses != 2) $display("FAIL div_div_pulses: got %0d want 2", pulses); else n_pass++;
        n_chk++; if (md_busy !== 1'b0) $display("FAIL div2_done: got %b want 0", md_busy); else n_pass++;
        n_chk++; if (stall_cnt !== exp_cnt) $display("FAIL div_div_cnt: got %0d want %0d", stall_cnt, exp_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_div();
        idle_inputs();
        md_start_D = 1'b1; md_div_D = 1'b1;
        tick();
        md_start_D = 1'b0; md_div_D = 1'b0;
        tick(); tick(); tick();
        md_use_D = 1'b1;
        #1;
        n_chk++; if (flush_IDEX !== 1'b1) $display("FAIL div_mid_stall: got %b want 1", flush_IDEX); else n_pass++;
        reset = 1'b0;
        #1;
        exp_cnt = 32'd0;
        n_chk++; if ({md_busy, md_start_E} !== 2'b00) $display("FAIL async_rst_busy: got %b want 00", {md_busy, md_start_E}); else n_pass++;
        n_chk++; if (stall_cnt !== exp_cnt) $display("FAIL async_rst_cnt: got %h want 0", stall_cnt); else n_pass++;
        n_chk++; if (flush_IDEX !== 1'b0) $display("FAIL async_rst_flush: got %b want 0", flush_IDEX); else n_pass++;
        @(negedge CLK);
        reset = 1'b1;
        tick();
        n_chk++; if ({md_busy, md_start_E, flush_IDEX} !== 3'b000) $display("FAIL post_rst: got %b want 000", {md_busy, md_start_E, flush_IDEX}); else n_pass++;
        tick();
        n_chk++; if (stall_cnt !== exp_cnt) $display("FAIL post_rst_cnt: got %0d want %0d", stall_cnt, exp_cnt); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_saturation();
        idle_inputs();
        rs_D = 5'd5; rs_tuse_D = 2'd1; wa_E = 5'd5; tnew_E = 2'd2;
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        tick();
        n_chk++; if (stall_cnt !== 32'hFFFF_FFFF) $display("FAIL sat_reach: got %h want ffffffff", stall_cnt); else n_pass++;
        tick();
        tick();
        n_chk++; if (stall_cnt !== 32'hFFFF_FFFF) $display("FAIL sat_hold: got %h want ffffffff", stall_cnt); else n_pass++;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mult_mflo();
        test_back_to_back();
        test_reset_mid_div();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
